// File: rtl/somador_8bits.sv
// somador_8bits: registered N-bit unsigned adder built from a ripple chain of
// full-adder cells, with carry-out in S[N], a signed-overflow flag and a
// one-cycle valid pulse. Only the output registers hold state.

// One full-adder cell of the ripple chain.
module somador_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module somador_8bits #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         in_valid,
  output logic [N:0]   S,
  output logic         out_valid,
  output logic         ovf
);

  logic [N:0]   carry;
  logic [N-1:0] sum_bits;
  logic [N:0]   sum;
  logic         ovf_c;

  logic [N:0]   s_q, s_d;
  logic         ovf_q, ovf_d;
  logic         out_valid_q, out_valid_d;

  // Carry-in of the chain is tied low; cell i feeds its carry to cell i+1.
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    somador_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .c  (carry[i]),
      .s  (sum_bits[i]),
      .co (carry[i+1])
    );
  end

  // Final carry becomes the MSB, so the full N+1-bit result is never truncated.
  assign sum   = {carry[N], sum_bits};
  // Signed overflow: operands share a sign that the N-bit result does not.
  assign ovf_c = (A[N-1] == B[N-1]) && (sum_bits[N-1] != A[N-1]);

  // Next-state: load on a valid pair, otherwise hold; valid pulse follows in_valid.
  always_comb begin
    s_d         = s_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d   = sum;
      ovf_d = ovf_c;
    end
  end

  // Output registers; reset clears result, flag and pending valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S         = s_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_somador_8bits.sv
// Directed + short random bench for somador_8bits with an expected-result queue.
module tb_somador_8bits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] A, B;
  logic       in_valid;
  logic [8:0] S;
  logic       out_valid;
  logic       ovf;

  typedef struct packed {
    logic [8:0] s;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  somador_8bits #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .S         (S),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.s   = {1'b0, a} + {1'b0, b};
    e.ovf = (a[7] == b[7]) && (e.s[7] != a[7]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then check outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input string tag);
    in_valid = v;
    A        = a;
    B        = b;
    if (v) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, {8'h0, out_valid}, {8'h0, v});
    if (v) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
        last = sb.pop_front();
      end
    end
    chk({tag, "_s"}, S, last.s);
    chk({tag, "_ovf"}, {8'h0, ovf}, {8'h0, last.ovf});
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    last     = '0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_s", S, 9'h000);
    chk("rst_ovf", {8'h0, ovf}, 9'h000);
    chk("rst_vld", {8'h0, out_valid}, 9'h000);

    // Valid input during reset is ignored.
    in_valid = 1'b1; A = 8'hFF; B = 8'hFF;
    @(posedge clk); #1;
    chk("rst_edge_s", S, 9'h000);
    chk("rst_edge_vld", {8'h0, out_valid}, 9'h000);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Directed values incl. carry and overflow boundaries.
    step(1'b1, 8'h00, 8'h00, "zero");
    step(1'b1, 8'h01, 8'h01, "one");
    step(1'b1, 8'h55, 8'h2A, "mid");
    step(1'b1, 8'hFF, 8'h01, "wrap");
    step(1'b1, 8'hFF, 8'hFF, "max");
    step(1'b1, 8'h7F, 8'h01, "sovf");
    step(1'b1, 8'h80, 8'h80, "negovf");
    chk("wrap_const", model(8'hFF, 8'h01).s, 9'h100);

    // Hold: result stays while in_valid is low, operands ignored.
    step(1'b1, 8'h10, 8'h20, "hold_ld");
    chk("hold_ld_abs", S, 9'h030);
    step(1'b0, 8'hAB, 8'hCD, "hold1");
    step(1'b0, 8'h7F, 8'h7F, "hold2");
    chk("hold_abs", S, 9'h030);

    // Reset pulse between edges while a result is valid.
    step(1'b1, 8'h7F, 8'h7F, "pre_rst");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("pulse_s", S, 9'h000);
    chk("pulse_ovf", {8'h0, ovf}, 9'h000);
    chk("pulse_vld", {8'h0, out_valid}, 9'h000);
    #1 rst_n = 1'b1;
    last = '0;
    step(1'b0, 8'h12, 8'h34, "post_rst");

    // Reset asserted with a pair pending: nothing emerges.
    in_valid = 1'b1; A = 8'h44; B = 8'h44;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midop_vld", {8'h0, out_valid}, 9'h000);
    chk("midop_s", S, 9'h000);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 8'h44, 8'h44, "midop_after");

    // Streaming: back-to-back valid pairs, then some random ones.
    step(1'b1, 8'h01, 8'h02, "st0");
    step(1'b1, 8'h80, 8'h7F, "st1");
    step(1'b1, 8'hC0, 8'hC0, "st2");
    step(1'b1, 8'h40, 8'h40, "st3");
    step(1'b1, 8'hFE, 8'h03, "st4");
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rnd");
    end
    step(1'b0, 8'h00, 8'h00, "tail");
    chk("sb_empty", 9'(sb.size()), 9'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/somador_8bits.md
SOMADOR_8BITS -- requirements
Module: somador_8bits

Interface
REQ-001 Parameter: N, default 8, operand width in bits; only N = 8 is required to be verified.
REQ-002 Port: clk  input  1  rising-edge clock for all registers.
REQ-003 Port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port: A  input  N  first operand, unsigned.
REQ-005 Port: B  input  N  second operand, unsigned.
REQ-006 Port: in_valid  input  1  high marks A and B as a valid operand pair this cycle.
REQ-007 Port: S  output  N+1  registered unsigned sum; S[N] is the carry-out.
REQ-008 Port: out_valid  output  1  high for exactly one cycle when S holds a new result.
REQ-009 Port: ovf  output  1  registered two's-complement signed overflow of A + B.

Function
REQ-010 The sum SHALL be computed as a ripple-carry chain of N full-adder cells with carry-in fixed at 0.
- Per cell: s = a ^ b ^ c; c_out = a&b | a&c | b&c.
REQ-011 The chain's final carry SHALL drive S[N]; S SHALL equal A + B exactly, range 0 to 2^(N+1)-2, with no truncation or saturation.
REQ-012 On a rising clk edge with in_valid = 1, S SHALL load A + B and ovf SHALL load (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]).
REQ-013 Latency from sampled operands to S, ovf and out_valid SHALL be exactly 1 clock cycle.
REQ-014 out_valid SHALL be high in the cycle following each cycle in which in_valid = 1, and low otherwise.
REQ-015 On an edge with in_valid = 0, S and ovf SHALL hold their previous values.
REQ-016 With in_valid held high, back-to-back operand pairs SHALL be accepted every cycle with no stall and no bubble.
REQ-017 A and B SHALL have no effect on any output while in_valid = 0.
REQ-018 The block SHALL have no handshake back-pressure; every valid input is accepted.
REQ-019 Wrap-around: 255 + 1 SHALL produce S = 9'h100 with carry set.
- The low 8 bits of S are 0.
- No other flag besides ovf is generated.

Reset
REQ-020 While rst_n = 0, S SHALL be 0, ovf SHALL be 0 and out_valid SHALL be 0, asynchronously and independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard any pending result, so out_valid stays 0.
REQ-022 Operation SHALL resume with the first rising edge at which rst_n = 1 and in_valid = 1.
REQ-023 All state SHALL be held in the output registers; the adder chain itself SHALL be purely combinational.

Verification
REQ-024 Zero and small values, each pair with in_valid = 1 followed by one clock:
- A = 0x00, B = 0x00 -> S = 9'h000, ovf = 0, out_valid = 1.
- A = 0x01, B = 0x01 -> S = 9'h002, ovf = 0.
REQ-025 A = 0x55 (85), B = 0x2A (42) -> S = 9'h07F (127), ovf = 0.
REQ-026 Carry-out boundary:
- A = 0xFF, B = 0x01 -> S = 9'h100 (256), ovf = 0.
- A = 0xFF, B = 0xFF -> S = 9'h1FE (510), ovf = 0.
REQ-027 Signed overflow: A = 0x7F, B = 0x01 -> S = 9'h080, ovf = 1.
REQ-028 Hold, then reset:
- Apply A = 0x10, B = 0x20 with in_valid = 1, then in_valid = 0 with A and B changed -> S stays 9'h030 and out_valid drops to 0.
- Then pulse rst_n low between clock edges -> S = 0, ovf = 0 and out_valid = 0 immediately.
REQ-029 Streaming: apply five consecutive valid pairs -> five consecutive out_valid pulses, each S matching its pair one cycle later.
